// File: rtl/cw_xtalk_monitor.sv
// Crosstalk monitor for the 3C1S encoder codeword stream: counts toggles and
// opposite-direction neighbour transitions on a ROWS x ROW_W TSV grid over a start/stop window.
module cw_xtalk_monitor #(
   parameter int unsigned CW_W      = 108,
   parameter int unsigned ROW_W     = 12,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned OPP_LIMIT = 1
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      cw_valid,
   input  logic [CW_W-1:0]           codeout,
   output logic                      busy,
   output logic                      done,
   output logic [CNT_W-1:0]          cycles,
   output logic [CNT_W-1:0]          toggle_total,
   output logic [$clog2(CW_W+1)-1:0] toggle_max,
   output logic [CNT_W-1:0]          opp_total,
   output logic [CNT_W-1:0]          viol_cycles
);

   localparam int unsigned ROWS   = CW_W / ROW_W;
   localparam int unsigned TOG_W  = $clog2(CW_W + 1);
   localparam int unsigned NPAIRS = ROWS * (ROW_W - 1) + (ROWS - 1) * ROW_W;
   localparam int unsigned OPP_W  = $clog2(NPAIRS + 1);

   generate
      if ((CW_W % ROW_W) != 0) begin : g_bad_geometry
         $error("cw_xtalk_monitor: CW_W must be a multiple of ROW_W");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic              drain_q, drain_d;
   logic              clear_c, issue_c, load_c;

   logic [CW_W-1:0]   prev_q;
   logic              s1_vld_q;
   logic [CW_W-1:0]   rise_q, fall_q;
   logic              s2_vld_q;
   logic [TOG_W-1:0]  tog_q;
   logic [OPP_W-1:0]  opp_q;
   logic              viol_q;

   logic [TOG_W-1:0]  tog_c;
   logic [OPP_W-1:0]  opp_c;
   logic              viol_c;
   logic [2:0]        nopp_c [CW_W];

   logic              busy_q, done_q;
   logic [CNT_W-1:0]  cycles_q, toggle_total_q, opp_total_q, viol_cycles_q;
   logic [TOG_W-1:0]  toggle_max_q;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   function automatic logic opp_pair(input logic ra, input logic fa,
                                     input logic rb, input logic fb);
      return (ra & fb) | (fa & rb);
   endfunction

   // Window control FSM
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      clear_c = 1'b0;
      issue_c = 1'b0;
      load_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_PRIME;
               clear_c = 1'b1;
            end
         end
         S_PRIME: begin
            // An empty window closes immediately; the first codeword only seeds prev.
            if (stop) begin
               state_d = S_DONE;
            end else if (cw_valid) begin
               load_c  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cw_valid) begin
               issue_c = 1'b1;
               load_c  = 1'b1;
            end
            if (stop) begin
               state_d = S_DRAIN;
               drain_d = 1'b0;
            end
         end
         S_DRAIN: begin
            if (drain_q) begin
               state_d = S_DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         S_DONE: begin
            if (start) begin
               state_d = S_PRIME;
               clear_c = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stage 1: previous codeword and per-bit transition direction
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         prev_q   <= '0;
         s1_vld_q <= 1'b0;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         s1_vld_q <= issue_c;
         if (issue_c) begin
            rise_q <= ~prev_q & codeout;
            fall_q <= prev_q & ~codeout;
         end
         if (load_c) begin
            prev_q <= codeout;
         end
      end
   end

   // Stage 2 combinational: toggles, opposite neighbour pairs, per-bit opposite counts
   always_comb begin
      tog_c  = '0;
      opp_c  = '0;
      viol_c = 1'b0;
      for (int i = 0; i < CW_W; i++) begin
         nopp_c[i] = 3'd0;
      end
      for (int i = 0; i < CW_W; i++) begin
         tog_c = tog_c + TOG_W'(rise_q[i] | fall_q[i]);
      end
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < ROW_W - 1; c++) begin
            if (opp_pair(rise_q[r*ROW_W+c], fall_q[r*ROW_W+c],
                         rise_q[r*ROW_W+c+1], fall_q[r*ROW_W+c+1])) begin
               opp_c                = opp_c + OPP_W'(1);
               nopp_c[r*ROW_W+c]    = nopp_c[r*ROW_W+c] + 3'd1;
               nopp_c[r*ROW_W+c+1]  = nopp_c[r*ROW_W+c+1] + 3'd1;
            end
         end
      end
      for (int i = 0; i < CW_W - ROW_W; i++) begin
         if (opp_pair(rise_q[i], fall_q[i], rise_q[i+ROW_W], fall_q[i+ROW_W])) begin
            opp_c            = opp_c + OPP_W'(1);
            nopp_c[i]        = nopp_c[i] + 3'd1;
            nopp_c[i+ROW_W]  = nopp_c[i+ROW_W] + 3'd1;
         end
      end
      for (int i = 0; i < CW_W; i++) begin
         if (32'(nopp_c[i]) > OPP_LIMIT) begin
            viol_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q <= 1'b0;
         tog_q    <= '0;
         opp_q    <= '0;
         viol_q   <= 1'b0;
      end else begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            tog_q  <= tog_c;
            opp_q  <= opp_c;
            viol_q <= viol_c;
         end
      end
   end

   // Saturating window accumulators and status flags
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cycles_q       <= '0;
         toggle_total_q <= '0;
         toggle_max_q   <= '0;
         opp_total_q    <= '0;
         viol_cycles_q  <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         busy_q <= (state_d == S_PRIME) || (state_d == S_RUN) || (state_d == S_DRAIN);
         done_q <= (state_d == S_DONE);
         if (clear_c) begin
            cycles_q       <= '0;
            toggle_total_q <= '0;
            toggle_max_q   <= '0;
            opp_total_q    <= '0;
            viol_cycles_q  <= '0;
         end else if (s2_vld_q) begin
            cycles_q       <= sat_add(cycles_q, CNT_W'(1));
            toggle_total_q <= sat_add(toggle_total_q, CNT_W'(tog_q));
            opp_total_q    <= sat_add(opp_total_q, CNT_W'(opp_q));
            viol_cycles_q  <= sat_add(viol_cycles_q, CNT_W'(viol_q));
            if (tog_q > toggle_max_q) begin
               toggle_max_q <= tog_q;
            end
         end
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign cycles       = cycles_q;
   assign toggle_total = toggle_total_q;
   assign toggle_max   = toggle_max_q;
   assign opp_total    = opp_total_q;
   assign viol_cycles  = viol_cycles_q;

endmodule

// File: tb/tb_cw_xtalk_monitor.sv
// Scoreboard bench for cw_xtalk_monitor: windows of codewords are scored by a grid-level
// reference model when issued; a monitor compares results when done rises.
module tb_cw_xtalk_monitor;

   localparam int unsigned CW_W      = 108;
   localparam int unsigned ROW_W     = 12;
   localparam int unsigned ROWS      = 9;
   localparam int unsigned CNT_W     = 12;
   localparam int unsigned OPP_LIMIT = 1;
   localparam int unsigned TOG_W     = 7;
   localparam longint     SAT        = (longint'(1) << CNT_W) - 1;

   typedef bit [CW_W-1:0] cw_t;
   typedef struct {
      longint cyc_n;
      longint tt;
      longint tmax;
      longint opp;
      longint viol;
      longint done_cyc;
   } exp_t;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             start, stop, cw_valid;
   logic [CW_W-1:0]  codeout;
   logic             busy, done;
   logic [CNT_W-1:0] cycles, toggle_total, opp_total, viol_cycles;
   logic [TOG_W-1:0] toggle_max;

   int     n_vec = 0;
   int     n_bad = 0;
   longint cyc   = 0;
   exp_t   sb_q[$];
   cw_t    win_q[$];
   bit     done_seen = 1'b0;

   cw_xtalk_monitor #(
      .CW_W(CW_W), .ROW_W(ROW_W), .CNT_W(CNT_W), .OPP_LIMIT(OPP_LIMIT)
   ) dut (
      .clock(clock), .rst_n(rst_n), .start(start), .stop(stop),
      .cw_valid(cw_valid), .codeout(codeout), .busy(busy), .done(done),
      .cycles(cycles), .toggle_total(toggle_total), .toggle_max(toggle_max),
      .opp_total(opp_total), .viol_cycles(viol_cycles)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sat(input longint x);
      return (x > SAT) ? SAT : x;
   endfunction

   // Reference: classify each bit as rise(+1)/fall(-1)/none(0); opposite neighbours multiply to -1.
   function automatic void model(output exp_t e);
      int  d[CW_W];
      int  nn[CW_W];
      int  tog, opp, k;
      bit  v;
      cw_t a, b;
      e = '{default: 0};
      for (int t = 1; t < win_q.size(); t++) begin
         a = win_q[t-1];
         b = win_q[t];
         tog = 0; opp = 0; v = 1'b0;
         for (int i = 0; i < CW_W; i++) begin
            d[i]  = (!a[i] && b[i]) ? 1 : ((a[i] && !b[i]) ? -1 : 0);
            nn[i] = 0;
            if (d[i] != 0) tog++;
         end
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < ROW_W; c++) begin
               k = r * ROW_W + c;
               if (c + 1 < ROW_W && d[k] * d[k+1] == -1) begin
                  opp++; nn[k]++; nn[k+1]++;
               end
               if (r + 1 < ROWS && d[k] * d[k+ROW_W] == -1) begin
                  opp++; nn[k]++; nn[k+ROW_W]++;
               end
            end
         end
         for (int i = 0; i < CW_W; i++) begin
            if (nn[i] > int'(OPP_LIMIT)) v = 1'b1;
         end
         e.cyc_n = sat(e.cyc_n + 1);
         e.tt    = sat(e.tt + tog);
         e.opp   = sat(e.opp + opp);
         e.viol  = sat(e.viol + longint'(v));
         if (tog > e.tmax) e.tmax = tog;
      end
   endfunction

   // Monitor: one scoreboard entry per rising edge of done
   always @(negedge clock) begin : mon
      exp_t e;
      if (!rst_n) begin
         done_seen = 1'b0;
      end else begin
         if (done && !done_seen) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("done_time", cyc, e.done_cyc);
               chk("busy_in_done", longint'(busy), 0);
               chk("cycles", longint'(cycles), e.cyc_n);
               chk("toggle_total", longint'(toggle_total), e.tt);
               chk("toggle_max", longint'(toggle_max), e.tmax);
               chk("opp_total", longint'(opp_total), e.opp);
               chk("viol_cycles", longint'(viol_cycles), e.viol);
            end
         end
         done_seen = done;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, longint'(busy), 0);
      chk({tag, "_done"}, longint'(done), 0);
      chk({tag, "_cycles"}, longint'(cycles), 0);
      chk({tag, "_toggle_total"}, longint'(toggle_total), 0);
      chk({tag, "_toggle_max"}, longint'(toggle_max), 0);
      chk({tag, "_opp_total"}, longint'(opp_total), 0);
      chk({tag, "_viol_cycles"}, longint'(viol_cycles), 0);
   endtask

   task automatic wait_sb();
      for (int t = 0; t < 20; t++) begin
         if (sb_q.size() == 0) break;
         @(negedge clock);
      end
      if (sb_q.size() != 0) begin
         chk("done_timeout", longint'(sb_q.size()), 0);
         sb_q.delete();
      end
   endtask

   function automatic cw_t rnd_cw();
      bit [127:0] w;
      for (int i = 0; i < 4; i++) w[i*32 +: 32] = $urandom;
      return w[CW_W-1:0];
   endfunction

   // Drives one window from IDLE/DONE; called at a negedge with all inputs low.
   task automatic run_window(input int gmin, input int gmax, input bit stop_last);
      exp_t e;
      int   n;
      bit   stopped;
      n = win_q.size();
      model(e);
      stopped = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         idle(int'($urandom_range(gmax, gmin)));
         cw_valid = 1'b1;
         codeout  = win_q[i];
         if (i == n - 1 && n >= 2 && stop_last) begin
            stop       = 1'b1;
            e.done_cyc = cyc + 3;
            sb_q.push_back(e);
            stopped    = 1'b1;
         end
         @(negedge clock);
         cw_valid = 1'b0;
         stop     = 1'b0;
      end
      if (!stopped) begin
         idle(int'($urandom_range(gmax, gmin)));
         stop       = 1'b1;
         e.done_cyc = (n == 0) ? cyc + 1 : cyc + 3;
         sb_q.push_back(e);
         @(negedge clock);
         stop = 1'b0;
      end
      wait_sb();
      idle(1);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      cw_t  w, one;
      exp_t e;
      int   n, m;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cw_valid = 1'b0; codeout = '0;
      repeat (3) @(negedge clock);
      chk_zero("reset");
      rst_n = 1'b1;
      idle(1);

      // Abort a window by reset after 5 transitions
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cw_valid = 1'b1;
         codeout  = rnd_cw();
         @(negedge clock);
      end
      cw_valid = 1'b0;
      idle(1);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_mid");
      @(negedge clock);
      rst_n = 1'b1;
      idle(1);
      win_q.delete();
      run_window(0, 0, 1'b0);

      // 0 -> ones -> 0
      win_q.delete();
      win_q.push_back('0); win_q.push_back('1); win_q.push_back('0);
      run_window(0, 2, 1'b0);

      // Row checkerboard then inverse
      w = '0;
      for (int i = 0; i < CW_W; i++) w[i] = ((i % ROW_W) % 2 == 0);
      win_q.delete();
      win_q.push_back(w); win_q.push_back(~w);
      run_window(0, 1, 1'b1);

      // Identical codewords with gaps
      w = rnd_cw();
      win_q.delete();
      for (int i = 0; i < 4; i++) win_q.push_back(w);
      run_window(1, 3, 1'b0);

      // Saturation of toggle_total
      win_q.delete();
      for (int i = 0; i < 41; i++) win_q.push_back((i % 2 == 0) ? cw_t'(0) : ~cw_t'(0));
      run_window(0, 0, 1'b1);

      // start+stop together in DONE: start wins, counters cleared
      start = 1'b1; stop = 1'b1;
      @(negedge clock);
      start = 1'b0; stop = 1'b0;
      chk("done_startstop_busy", longint'(busy), 1);
      chk("done_startstop_done", longint'(done), 0);
      chk("done_startstop_cycles", longint'(cycles), 0);
      chk("done_startstop_tt", longint'(toggle_total), 0);
      chk("done_startstop_tmax", longint'(toggle_max), 0);
      win_q.delete();
      model(e);
      stop       = 1'b1;
      e.done_cyc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clock);
      stop = 1'b0;
      wait_sb();
      idle(1);

      // Randomized windows mixing dense, sparse and static traffic
      for (int wdx = 0; wdx < 30; wdx++) begin
         win_q.delete();
         n = int'($urandom_range(8, 0));
         w = rnd_cw();
         for (int i = 0; i < n; i++) begin
            m = int'($urandom_range(3, 0));
            if (m == 0) begin
               w = rnd_cw();
            end else if (m == 1) begin
               one = cw_t'(1);
               w = w ^ (one << $urandom_range(CW_W - 1, 0)) ^ (one << $urandom_range(CW_W - 1, 0));
            end else if (m == 2) begin
               w = ~w;
            end
            win_q.push_back(w);
         end
         run_window(0, 2, 1'($urandom_range(1, 0)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
